// File: rtl/pmci_vdm_tx_sequencer.sv
// pmci_vdm_tx_sequencer
//
// Takes one outbound MCTP-over-VDM packet from a 32-bit stream source and
// stores it. It then sends the packet into the PMCI VDM mailbox over an AVMM
// master, in three phases:
//   1. Poll VDM_FCR until its TX-busy bit (bit 0) reads 0. A gap of POLL_GAP
//      cycles separates consecutive polls.
//   2. Write every buffered DW to VDM_PDR, in order.
//   3. Commit the packet by writing VDM_FCR = {len_dw[9:0], 1'b1}.
//
// Optional feature, macro PMCI_VDM_TX_TIMEOUT_EN:
//   - When defined: after TIMEOUT_POLLS busy polls the packet is dropped and
//     err_timeout is set.
//   - When undefined: polling continues without limit and err_timeout is
//     tied to 0.
//
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   s_valid/s_ready/s_data/s_last
//                           inbound packet stream (valid/ready handshake)
//   avmm_address/_write/_read/_writedata
//                           AVMM master request outputs
//   avmm_waitrequest/_readdata/_readdatavalid
//                           AVMM slave responses
//   pkt_sent                1-cycle pulse when the FCR commit write is accepted
//   busy                    sequencer is not idle
//   err_trunc               sticky: packet was cut at MAX_DW words
//   err_timeout             sticky: poll timeout abort (optional feature)
//   err_clr                 clears both sticky errors; a same-cycle set wins
module pmci_vdm_tx_sequencer #(
  parameter int unsigned        ADDR_W        = 20,
  parameter logic [ADDR_W-1:0]  FCR_ADDR      = 20'h22000,
  parameter logic [ADDR_W-1:0]  PDR_ADDR      = 20'h22008,
  parameter int unsigned        MAX_DW        = 256,
  parameter int unsigned        POLL_GAP      = 8,
  parameter int unsigned        TIMEOUT_POLLS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic [ADDR_W-1:0] avmm_address,
  output logic              avmm_write,
  output logic              avmm_read,
  output logic [31:0]       avmm_writedata,
  input  logic              avmm_waitrequest,
  input  logic [31:0]       avmm_readdata,
  input  logic              avmm_readdatavalid,
  output logic              pkt_sent,
  output logic              busy,
  output logic              err_trunc,
  output logic              err_timeout,
  input  logic              err_clr
);

  // Counter widths derived from the parameters.
  localparam int unsigned CW = $clog2(MAX_DW + 1);                   // word count
  localparam int unsigned AW = $clog2(MAX_DW);                       // buffer index
  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1; // poll gap
  localparam int unsigned PW = $clog2(TIMEOUT_POLLS + 1);            // busy polls

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL_RD,
    S_POLL_WAIT,
    S_GAP,
    S_WR_DATA,
    S_WR_FCR,
    S_ABORT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          pkt_rdy_q, pkt_rdy_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          err_trunc_q, err_trunc_d;
  logic          trunc_evt;
  logic          accept;
  logic [31:0]   wr_cnt_ext;
  logic [31:0]   buf_mem [MAX_DW];

`ifdef PMCI_VDM_TX_TIMEOUT_EN
  logic          err_timeout_q, err_timeout_d;
  logic          timeout_evt;
`endif

  // Bits that are intentionally unused: only bit 0 of FCR readdata carries
  // information, and only the low 10 bits of the length enter the FCR word.
  logic unused_bits;
  assign unused_bits = ^{avmm_readdata[31:1], wr_cnt_ext[31:10]};

  assign s_ready    = (state_q == S_IDLE) && !pkt_rdy_q;
  assign accept     = s_valid && s_ready;
  assign busy       = (state_q != S_IDLE);
  assign err_trunc  = err_trunc_q;
  // Length field is len_dw[9:0]; a 1024-DW packet wraps to 0 by design.
  assign wr_cnt_ext = 32'(wr_cnt_q);

`ifdef PMCI_VDM_TX_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Packet buffer. It is a plain RAM with no reset: unused entries are never read.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[wr_cnt_q[AW-1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_rdy_q   <= 1'b0;
      gap_q       <= '0;
      poll_q      <= '0;
      err_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_rdy_q   <= pkt_rdy_d;
      gap_q       <= gap_d;
      poll_q      <= poll_d;
      err_trunc_q <= err_trunc_d;
    end
  end

`ifdef PMCI_VDM_TX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_timeout_q <= 1'b0;
    end else begin
      err_timeout_q <= err_timeout_d;
    end
  end
`endif

  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    rd_ptr_d       = rd_ptr_q;
    pkt_rdy_d      = pkt_rdy_q;
    gap_d          = gap_q;
    poll_d         = poll_q;
    trunc_evt      = 1'b0;
    avmm_read      = 1'b0;
    avmm_write     = 1'b0;
    avmm_address   = '0;
    avmm_writedata = '0;
    pkt_sent       = 1'b0;
`ifdef PMCI_VDM_TX_TIMEOUT_EN
    timeout_evt    = 1'b0;
`endif

    // Stream intake. It can only happen in IDLE with no packet pending, so it
    // never competes with the drain side for wr_cnt or pkt_rdy.
    if (accept) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (s_last) begin
        pkt_rdy_d = 1'b1;
      end else if (wr_cnt_q == CW'(MAX_DW - 1)) begin
        // The buffer is full but the packet has not ended: close it here.
        pkt_rdy_d = 1'b1;
        trunc_evt = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pkt_rdy_q) begin
          state_d = S_POLL_RD;
        end
      end

      S_POLL_RD: begin
        avmm_read    = 1'b1;
        avmm_address = FCR_ADDR;
        if (!avmm_waitrequest) begin
          state_d = S_POLL_WAIT;
        end
      end

      S_POLL_WAIT: begin
        if (avmm_readdatavalid) begin
          if (avmm_readdata[0]) begin
            poll_d = poll_q + 1'b1;
            state_d = S_GAP;
`ifdef PMCI_VDM_TX_TIMEOUT_EN
            if (32'(poll_q) + 32'd1 >= TIMEOUT_POLLS) begin
              state_d = S_ABORT;
            end
`endif
          end else begin
            rd_ptr_d = '0;
            state_d  = S_WR_DATA;
          end
        end
      end

      S_GAP: begin
        if (gap_q == GW'(POLL_GAP - 1)) begin
          gap_d   = '0;
          state_d = S_POLL_RD;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_WR_DATA: begin
        avmm_write     = 1'b1;
        avmm_address   = PDR_ADDR;
        avmm_writedata = buf_mem[rd_ptr_q[AW-1:0]];
        if (!avmm_waitrequest) begin
          if (rd_ptr_q == wr_cnt_q - 1'b1) begin
            state_d = S_WR_FCR;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end

      S_WR_FCR: begin
        avmm_write     = 1'b1;
        avmm_address   = FCR_ADDR;
        avmm_writedata = {21'd0, wr_cnt_ext[9:0], 1'b1};
        if (!avmm_waitrequest) begin
          pkt_sent  = 1'b1;
          wr_cnt_d  = '0;
          pkt_rdy_d = 1'b0;
          poll_d    = '0;
          state_d   = S_IDLE;
        end
      end

`ifdef PMCI_VDM_TX_TIMEOUT_EN
      S_ABORT: begin
        timeout_evt = 1'b1;
        wr_cnt_d    = '0;
        pkt_rdy_d   = 1'b0;
        poll_d      = '0;
        state_d     = S_IDLE;
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // Sticky errors: the clear is applied first, so an error event in the
    // same cycle overrides it.
    err_trunc_d = err_clr ? 1'b0 : err_trunc_q;
    if (trunc_evt) begin
      err_trunc_d = 1'b1;
    end
  end

`ifdef PMCI_VDM_TX_TIMEOUT_EN
  always_comb begin
    err_timeout_d = err_clr ? 1'b0 : err_timeout_q;
    if (timeout_evt) begin
      err_timeout_d = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pmci_vdm_tx_sequencer.sv
// Testbench for pmci_vdm_tx_sequencer.
//
// The bench keeps its own model of the expected mailbox traffic. Each
// generated stream is split into packets at s_last or at MAX_DW words, and
// each packet becomes its expected PDR/FCR write list. A cycle-stepped AVMM
// slave in the bench answers the FCR polls and logs every accepted write.
module tb_pmci_vdm_tx_sequencer;

  localparam int unsigned        ADDR_W   = 20;
  localparam logic [ADDR_W-1:0]  FCR      = 20'h22000;
  localparam logic [ADDR_W-1:0]  PDR      = 20'h22008;
  localparam int unsigned        MAX_DW   = 256;
  localparam int unsigned        POLL_GAP = 8;
  localparam int unsigned        TO_POLLS = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid, s_ready, s_last;
  logic [31:0]       s_data;
  logic [ADDR_W-1:0] avmm_address;
  logic              avmm_write, avmm_read;
  logic [31:0]       avmm_writedata;
  logic              avmm_waitrequest;
  logic [31:0]       avmm_readdata;
  logic              avmm_readdatavalid;
  logic              pkt_sent, busy, err_trunc, err_timeout, err_clr;

  always #5 clk = ~clk;

  pmci_vdm_tx_sequencer #(
    .ADDR_W(ADDR_W), .FCR_ADDR(FCR), .PDR_ADDR(PDR), .MAX_DW(MAX_DW),
    .POLL_GAP(POLL_GAP), .TIMEOUT_POLLS(TO_POLLS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .avmm_address(avmm_address), .avmm_write(avmm_write), .avmm_read(avmm_read),
    .avmm_writedata(avmm_writedata), .avmm_waitrequest(avmm_waitrequest),
    .avmm_readdata(avmm_readdata), .avmm_readdatavalid(avmm_readdatavalid),
    .pkt_sent(pkt_sent), .busy(busy), .err_trunc(err_trunc),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  typedef struct packed { logic [19:0] addr; logic [31:0] data; } xact_t;
  typedef struct packed { logic [31:0] data; logic last; } word_t;

  xact_t exp_q[$];
  xact_t obs_q[$];
  word_t src_q[$];

  int unsigned errors = 0;
  int unsigned checks = 0;

  int unsigned stall_pct = 0;
  int unsigned valid_pct = 100;
  int unsigned busy_left = 0;    // number of upcoming FCR polls that read busy
  logic        rdv_pend  = 1'b0;
  logic [31:0] rdv_data  = '0;
  int unsigned n_reads, n_sent, proto_err, mon_cnt, gen_cnt;
  int          cyc_n = 0;
  int          last_rd_cyc, min_rd_gap, last_word_cyc, sent_cyc;
  bit          model_pending = 1'b0;
  bit          allow_drop    = 1'b0;
  logic        prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
  logic [19:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Reference model: stream words to expected mailbox writes.
  task automatic push_word(input logic [31:0] d, input logic l);
    src_q.push_back('{data: d, last: l});
    exp_q.push_back('{addr: PDR, data: d});
    gen_cnt++;
    if (l || gen_cnt == MAX_DW) begin
      exp_q.push_back('{addr: FCR, data: 32'(((gen_cnt % 1024) << 1) | 1)});
      gen_cnt = 0;
    end
  endtask

  task automatic clear_stats();
    n_reads = 0; n_sent = 0; proto_err = 0;
    last_rd_cyc = -1; min_rd_gap = 1000000;
  endtask

  // One clock cycle. Entered just after a rising edge; drives the inputs,
  // samples the outputs mid-cycle, then waits for the next edge.
  task automatic cyc();
    logic [31:0] rnd;
    avmm_waitrequest   = (stall_pct != 0) && ($urandom_range(99) < stall_pct);
    avmm_readdatavalid = rdv_pend;
    avmm_readdata      = rdv_pend ? rdv_data : $urandom;
    rdv_pend           = 1'b0;
    if (src_q.size() != 0 && $urandom_range(99) < valid_pct) begin
      s_valid = 1'b1; s_data = src_q[0].data; s_last = src_q[0].last;
    end else begin
      s_valid = 1'b0; s_data = $urandom; s_last = 1'($urandom_range(1));
    end
    #2;
    if (rst_n) begin
      if (avmm_read && avmm_write) proto_err++;
      if (prev_stall && (avmm_read !== prev_rd || avmm_write !== prev_wr ||
                         avmm_address !== prev_addr || avmm_writedata !== prev_wdata))
        proto_err++;
      prev_stall = (avmm_read || avmm_write) && avmm_waitrequest;
      prev_rd = avmm_read; prev_wr = avmm_write;
      prev_addr = avmm_address; prev_wdata = avmm_writedata;
      if (s_ready && model_pending) begin
        if (allow_drop) model_pending = 1'b0;
        else proto_err++;
      end
      if (pkt_sent && !(avmm_write && !avmm_waitrequest && avmm_address === FCR))
        proto_err++;
      if (avmm_read && !avmm_waitrequest) begin
        if (avmm_address !== FCR) proto_err++;
        n_reads++;
        if (last_rd_cyc >= 0 && cyc_n - last_rd_cyc < min_rd_gap)
          min_rd_gap = cyc_n - last_rd_cyc;
        last_rd_cyc = cyc_n;
        rnd = $urandom;
        rdv_pend = 1'b1;
        rdv_data = {rnd[31:1], (busy_left != 0)};
        if (busy_left != 0) busy_left--;
      end
      if (avmm_write && !avmm_waitrequest)
        obs_q.push_back('{addr: avmm_address, data: avmm_writedata});
      if (pkt_sent) begin
        n_sent++; sent_cyc = cyc_n; model_pending = 1'b0;
      end
      if (s_valid && s_ready) begin
        void'(src_q.pop_front());
        mon_cnt++;
        if (s_last || mon_cnt == MAX_DW) begin
          model_pending = 1'b1; mon_cnt = 0; last_word_cyc = cyc_n;
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic run_until_sent(input int unsigned target, input int unsigned budget,
                                input string tag);
    int unsigned k = 0;
    while (n_sent < target && k < budget) begin
      cyc(); k++;
    end
    chk({tag, "_sent"}, 64'(n_sent), 64'(target));
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk(tag, 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_read"},   64'(avmm_read),      64'(0));
    chk({tag, "_write"},  64'(avmm_write),     64'(0));
    chk({tag, "_addr"},   64'(avmm_address),   64'(0));
    chk({tag, "_wdata"},  64'(avmm_writedata), 64'(0));
    chk({tag, "_sent"},   64'(pkt_sent),       64'(0));
    chk({tag, "_busy"},   64'(busy),           64'(0));
    chk({tag, "_trunc"},  64'(err_trunc),      64'(0));
    chk({tag, "_tmo"},    64'(err_timeout),    64'(0));
    // s_ready is 1 whenever the sequencer is idle with no packet buffered.
    chk({tag, "_sready"}, 64'(s_ready),        64'(1));
  endtask

  initial begin
    rst_n = 1'b0; err_clr = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    avmm_waitrequest = 1'b0; avmm_readdata = '0; avmm_readdatavalid = 1'b0;
    mon_cnt = 0; gen_cnt = 0; last_word_cyc = 0; sent_cyc = 0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_idle_outputs("reset");

    // 1) 4-DW packet, idle mailbox, no stalls.
    clear_stats();
    for (int i = 0; i < 4; i++) push_word($urandom, i == 3);
    run_until_sent(1, 100, "t1");
    chk("t1_busy_fall", 64'(busy), 64'(0));
    chk("t1_latency", 64'(sent_cyc - last_word_cyc), 64'(8));
    repeat (5) cyc();
    chk("t1_one_pulse", 64'(n_sent), 64'(1));
    chk("t1_reads", 64'(n_reads), 64'(1));
    chk("t1_fcr", 64'(obs_q.size() == 5 ? obs_q[4].data : 32'hdead), 64'(32'h9));
    chk("t1_proto", 64'(proto_err), 64'(0));
    check_log("t1_log");

    // 2) FCR busy for three polls.
    clear_stats();
    busy_left = 3;
    for (int i = 0; i < 3; i++) push_word($urandom, i == 2);
    run_until_sent(1, 300, "t2");
    chk("t2_reads", 64'(n_reads), 64'(4));
    chk("t2_spacing", 64'(min_rd_gap >= int'(POLL_GAP + 1)), 64'(1));
    chk("t2_proto", 64'(proto_err), 64'(0));
    check_log("t2_log");

    // 3) 16-DW packet with random stalls and a gappy source.
    clear_stats();
    stall_pct = 50; valid_pct = 70;
    for (int i = 0; i < 16; i++) push_word($urandom, i == 15);
    run_until_sent(1, 600, "t3");
    chk("t3_fcr", 64'(obs_q.size() == 17 ? obs_q[16].data : 32'hdead), 64'(32'h21));
    chk("t3_proto", 64'(proto_err), 64'(0));
    check_log("t3_log");

    // 4) 260 DW with s_last only on the final word: truncated at 256, and
    //    the remaining 4 words form the next packet.
    clear_stats();
    stall_pct = 25; valid_pct = 100;
    for (int i = 0; i < 260; i++) push_word($urandom, i == 259);
    run_until_sent(2, 3000, "t4");
    chk("t4_trunc", 64'(err_trunc), 64'(1));
    chk("t4_fcr", 64'(obs_q.size() > 256 ? obs_q[256].data : 32'hdead), 64'(32'h201));
    chk("t4_proto", 64'(proto_err), 64'(0));
    check_log("t4_log");
    stall_pct = 0;
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t4_clr", 64'(err_trunc), 64'(0));

`ifdef PMCI_VDM_TX_TIMEOUT_EN
    // 5) FCR stuck busy: the packet is dropped after TO_POLLS polls.
    begin
      int unsigned k;
      clear_stats();
      busy_left = 1000; allow_drop = 1'b1;
      push_word($urandom, 1'b0);
      push_word($urandom, 1'b1);
      k = 0;
      while (!busy && k < 50) begin cyc(); k++; end
      k = 0;
      while (busy && k < 300) begin cyc(); k++; end
      repeat (20) cyc();
      chk("t5_reads", 64'(n_reads), 64'(TO_POLLS));
      chk("t5_writes", 64'(obs_q.size()), 64'(0));
      chk("t5_tmo", 64'(err_timeout), 64'(1));
      chk("t5_sent", 64'(n_sent), 64'(0));
      chk("t5_sready", 64'(s_ready), 64'(1));
      busy_left = 0; allow_drop = 1'b0;
      obs_q.delete(); exp_q.delete();
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("t5_clr", 64'(err_timeout), 64'(0));
    end
`else
    chk("tmo_tied", 64'(err_timeout), 64'(0));
`endif

    // 6) Reset during WR_DATA while the second PDR write is on the bus.
    begin
      int unsigned k = 0;
      clear_stats();
      for (int i = 0; i < 4; i++) push_word($urandom, i == 3);
      while (obs_q.size() < 1 && k < 100) begin cyc(); k++; end
      chk("t6_first_wr", 64'(obs_q.size()), 64'(1));
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      rdv_pend = 1'b0; model_pending = 1'b0; mon_cnt = 0; gen_cnt = 0;
      obs_q.delete(); exp_q.delete(); src_q.delete();
      s_valid = 1'b0; avmm_waitrequest = 1'b0; avmm_readdatavalid = 1'b0;
      #1;
      check_idle_outputs("t6_rst");
      push_word($urandom, 1'b1);
      run_until_sent(1, 100, "t6");
      chk("t6_fcr", 64'(obs_q.size() == 2 ? obs_q[1].data : 32'hdead), 64'(32'h3));
      chk("t6_proto", 64'(proto_err), 64'(0));
      check_log("t6_log");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
